// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder end of the MEM-stage data-memory interface. Serves one load or
//   store at a time from a word-organised RAM with a fixed access latency and
//   stalls the pipeline while the access is outstanding.
//
//   Parameters
//     ADDR_W   word-address width, RAM depth is 2**ADDR_W x 32 bits
//     LATENCY  cycles from request acceptance to response (1..15)
//
//   Ports
//     clk         rising-edge clock
//     reset       synchronous, active-high reset
//     req_valid   request present (MemRead or MemWrite in MEM stage)
//     req_ready   responder can accept a request this cycle
//     req_we      1 = store, 0 = load
//     req_addr    byte address; word index is req_addr[ADDR_W+1:2]
//     req_wdata   store data
//     resp_valid  one-cycle pulse, access complete
//     resp_rdata  load data; holds the last load result between loads
//     resp_err    access error, qualified by resp_valid
//     stall       hold PC, IF/ID, ID/EX and EX/MEM this cycle
//
//   Build option
//     DMEM_ALIGN_CHECK_EN  when defined, a misaligned address or one with
//                          nonzero bits above the RAM range is flagged with
//                          resp_err; such stores are dropped and such loads
//                          return zero. Undefined: resp_err is always 0 and
//                          those address bits are ignored.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | ready; accepts a request when req_valid is high
//   WAIT  | access in flight, counter runs down to the response cycle
//   DONE  | resp_valid pulse; RAM access happened on the edge into DONE

module data_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_range
    $error("data_mem_responder: LATENCY must be within 1..15");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q;
  logic                commit;
  logic                req_err;

  logic [31:0]         mem_q [2**ADDR_W];

`ifdef DMEM_ALIGN_CHECK_EN
  assign req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_W+2] != '0);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[1:0], req_addr[31:ADDR_W+2]};
  assign req_err = 1'b0;
`endif

  // The _d copies of the captured request already hold the live inputs on an
  // IDLE->DONE transition (LATENCY==1), so the RAM access below always uses
  // the _d values on the commit edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          idx_d   = req_addr[ADDR_W+1:2];
          wdata_d = req_wdata;
          err_d   = req_err;
          cnt_d   = CNT_LOAD;
          if (LATENCY > 1) begin
            state_d = WAIT;
          end else begin
            state_d = DONE;
            commit  = 1'b1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          commit  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      // Read sees the pre-write value; only one access is ever in flight.
      if (commit && !we_d) begin
        rdata_q <= err_d ? 32'd0 : mem_q[idx_d];
      end
    end
  end

  // RAM contents survive reset; a store still in WAIT when reset hits never
  // reaches its commit edge and is lost.
  always_ff @(posedge clk) begin
    if (!reset && commit && we_d && !err_d) begin
      mem_q[idx_d] <= wdata_d;
    end
  end

  assign req_ready  = (state_q == IDLE) && !reset;
  assign resp_valid = (state_q == DONE) && !reset;
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = rdata_q;
  // Low in DONE so the pipeline advances on the response cycle.
  assign stall      = !reset && (((state_q == IDLE) && req_valid) || (state_q == WAIT));

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int AW = 10;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  int          sel;

  logic        vld  [3];
  logic        rdy  [3];
  logic        rv   [3];
  logic        rerr [3];
  logic        stl  [3];
  logic [31:0] rd   [3];

  int lat_of [3] = '{2, 1, 4};

  assign vld[0] = req_valid && (sel == 0);
  assign vld[1] = req_valid && (sel == 1);
  assign vld[2] = req_valid && (sel == 2);

  data_mem_responder #(.ADDR_W(AW), .LATENCY(2)) u_lat2 (
    .clk(clk), .reset(reset), .req_valid(vld[0]), .req_ready(rdy[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv[0]), .resp_rdata(rd[0]), .resp_err(rerr[0]), .stall(stl[0]));

  data_mem_responder #(.ADDR_W(AW), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset), .req_valid(vld[1]), .req_ready(rdy[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv[1]), .resp_rdata(rd[1]), .resp_err(rerr[1]), .stall(stl[1]));

  data_mem_responder #(.ADDR_W(AW), .LATENCY(4)) u_lat4 (
    .clk(clk), .reset(reset), .req_valid(vld[2]), .req_ready(rdy[2]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv[2]), .resp_rdata(rd[2]), .resp_err(rerr[2]), .stall(stl[2]));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] mdl [int];
  logic [31:0] last_rd [3];
  int          n_assert = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_err(input logic [31:0] a);
    if (!ALIGN) return 1'b0;
    return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
  endfunction

  // Model update and expected-response push at the moment a request is driven.
  task automatic push_exp(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int   key;
    bit   er;
    key = sel * (1 << AW) + int'(addr[AW+1:2]);
    er  = addr_err(addr);
    if (!we) last_rd[sel] = er ? 32'd0 : mdl[key];
    else if (!er) mdl[key] = wdata;
    e.rdata = last_rd[sel];
    e.err   = er;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    n_assert++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL %s.sb: observed response with empty scoreboard, expected none", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, ".rdata"}, rd[sel], e.rdata);
      check({tag, ".err"}, 32'(rerr[sel]), 32'(e.err));
    end
  endtask

  // One isolated transaction, driven at a negedge with the selected DUT idle.
  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata);
    int k;
    bit seen;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    #1;
    check({tag, ".stall_T"}, 32'(stl[sel]), 32'd1);
    check({tag, ".ready_T"}, 32'(rdy[sel]), 32'd1);
    push_exp(we, addr, wdata);
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = $urandom;
    req_wdata = $urandom;
    #1;
    k    = 1;
    seen = 1'b0;
    while (k <= 20 && !seen) begin
      check({tag, ".ready_busy"}, 32'(rdy[sel]), 32'd0);
      if (rv[sel]) begin
        seen = 1'b1;
        check({tag, ".latency"}, 32'(k), 32'(lat_of[sel]));
        check({tag, ".stall_done"}, 32'(stl[sel]), 32'd0);
        pop_check(tag);
      end else begin
        check({tag, ".stall_wait"}, 32'(stl[sel]), 32'd1);
        @(negedge clk);
        #1;
        k++;
      end
    end
    if (!seen) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s.timeout: observed no resp_valid in 20 cycles, expected one", tag);
    end
    @(negedge clk);
    #1;
    check({tag, ".idle_rv"}, 32'(rv[sel]), 32'd0);
    check({tag, ".idle_ready"}, 32'(rdy[sel]), 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    sel       = 0;
    for (int i = 0; i < 3; i++) last_rd[i] = 32'd0;

    // Reset then idle
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        check("rst.rv", 32'(rv[i]), 32'd0);
        check("rst.stall", 32'(stl[i]), 32'd0);
        check("rst.ready", 32'(rdy[i]), 32'd0);
        check("rst.rdata", rd[i], 32'd0);
      end
    end
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) check("post_rst.ready", 32'(rdy[i]), 32'd1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        check("idle.rv", 32'(rv[i]), 32'd0);
        check("idle.stall", 32'(stl[i]), 32'd0);
        check("idle.ready", 32'(rdy[i]), 32'd1);
      end
    end

    // LATENCY=2 store then load
    sel = 0;
    xact("l2_st10", 1'b1, 32'h10, 32'hDEADBEEF);
    xact("l2_ld10", 1'b0, 32'h10, 32'h0);
    check("l2_ld10.const", rd[0], 32'hDEADBEEF);
    xact("l2_st20", 1'b1, 32'h20, 32'h01020304);

    // LATENCY=1: preload, then back-to-back loads with req_valid held high
    sel = 1;
    xact("l1_st4", 1'b1, 32'h4, 32'h12345678);
    xact("l1_st0", 1'b1, 32'h0, 32'hCAFEF00D);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    #1;
    check("b2b.stall_T", 32'(stl[1]), 32'd1);
    push_exp(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    check("b2b.rv_T1", 32'(rv[1]), 32'd1);
    check("b2b.stall_T1", 32'(stl[1]), 32'd0);
    check("b2b.ready_T1", 32'(rdy[1]), 32'd0);
    pop_check("b2b.r0");
    check("b2b.r0.const", rd[1], 32'hCAFEF00D);
    req_addr = 32'h4;
    @(negedge clk);
    #1;
    check("b2b.rv_T2", 32'(rv[1]), 32'd0);
    check("b2b.stall_T2", 32'(stl[1]), 32'd1);
    check("b2b.ready_T2", 32'(rdy[1]), 32'd1);
    push_exp(1'b0, 32'h4, 32'h0);
    @(negedge clk);
    #1;
    check("b2b.rv_T3", 32'(rv[1]), 32'd1);
    pop_check("b2b.r1");
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    check("b2b.rv_end", 32'(rv[1]), 32'd0);

    // Held load data across a store response
    xact("held_ld4", 1'b0, 32'h4, 32'h0);
    xact("held_st0", 1'b1, 32'h0, 32'hAAAA5555);
    check("held.rdata", rd[1], 32'h12345678);
    xact("held_ld0", 1'b0, 32'h0, 32'h0);

    // LATENCY=4: reset two cycles after acceptance drops the store
    sel = 2;
    xact("l4_pre20", 1'b1, 32'h20, 32'h0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h55;
    #1;
    check("midrst.stall_T", 32'(stl[2]), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("midrst.rv_T1", 32'(rv[2]), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst.ready_rst", 32'(rdy[2]), 32'd0);
    check("midrst.stall_rst", 32'(stl[2]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) last_rd[i] = 32'd0;
    #1;
    check("midrst.rdata", rd[2], 32'd0);
    for (int c = 0; c < 6; c++) begin
      check("midrst.rv", 32'(rv[2]), 32'd0);
      check("midrst.ready", 32'(rdy[2]), 32'd1);
      @(negedge clk);
      #1;
    end
    xact("l4_ld20", 1'b0, 32'h20, 32'h0);
    check("l4_ld20.const", rd[2], 32'h0);

    // Address-bit handling (error responses when the check is built in)
    sel = 0;
    xact("al_st22", 1'b1, 32'h22, 32'h77);
    xact("al_ld20", 1'b0, 32'h20, 32'h0);
    check("al_ld20.const", rd[0], ALIGN ? 32'h01020304 : 32'h77);
    xact("al_ld23", 1'b0, 32'h23, 32'h0);
    xact("al_sthi", 1'b1, 32'h1000_0010, 32'h99);
    xact("al_ld10", 1'b0, 32'h10, 32'h0);
    xact("al_ldhi", 1'b0, 32'h8000_0020, 32'h0);

    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_drain: observed %0d pending, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
